y1_word_deserializer: RTL and testbench

// - Upstream feeder for the y1 16-input pattern-detector cone. Assembles a serial bit stream into
//   16-bit words and presents each word on word_data; word_data[i] drives detector input pi<i>.
// - Provides a valid/ready handshake on both sides, with 2-entry output buffering, so the detector

---
 rtl/y1_pkg.sv | 12 +
 rtl/y1_word_fifo2.sv | 70 +++++++
 rtl/y1_word_deserializer.sv | 114 +++++++++++
 tb/tb_y1_word_deserializer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y1_pkg.sv
// Shared definitions for the y1 detector front end: word geometry, bit
// ordering default and output buffer depth. The detector stage imports
// this package too, so both sides agree on the word type.
package y1_pkg;

    localparam int Y1_WORD_W    = 16;
    localparam bit Y1_LSB_FIRST = 1'b1;
    localparam int Y1_DEPTH     = 2;

    typedef logic [Y1_WORD_W-1:0] y1_word_t;

endpackage

// File: rtl/y1_word_fifo2.sv
// Two-entry word FIFO between the deserializer and the pattern detector.
// A push and a pop in the same cycle are both honoured, even when full,
// because the pop frees the slot the push lands in.
module y1_word_fifo2 #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    import y1_pkg::*;

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [WORD_W-1:0] mem_q [2];
    logic [WORD_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == 2'd0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset on purpose, because word_data must read zero out of reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments here keep every flop sampling pre-edge values.
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/y1_word_deserializer.sv
// Serial-to-parallel front end for the y1 16-input pattern detector.
// Bits are shifted into a word register, and each completed word is pushed
// into a 2-entry FIFO whose head drives word_data. A sin_sof arriving
// mid-word throws away the partial word and restarts assembly.
module y1_word_deserializer #(
    parameter int WORD_W    = y1_pkg::Y1_WORD_W,
    parameter bit LSB_FIRST = y1_pkg::Y1_LSB_FIRST,
    parameter int DEPTH     = y1_pkg::Y1_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin_valid,
    input  logic              sin_bit,
    input  logic              sin_sof,
    output logic              sin_ready,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              sof_abort,
    output logic [15:0]       word_cnt
);
    import y1_pkg::*;

    localparam int                 IDX_W     = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(WORD_W - 1);
    localparam int                 FIRST_POS = LSB_FIRST ? 0 : WORD_W - 1;

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              sof_abort_q, sof_abort_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              ready_en_q;

    logic              accept;
    logic              pop;
    logic              push;
    logic [WORD_W-1:0] push_word;
    logic [IDX_W-1:0]  pos;
    logic              fifo_full;
    logic              fifo_empty;

    // A completing bit needs a free FIFO slot; bits before it can always be taken.
    assign sin_ready  = ready_en_q && !(fifo_full && (bit_idx_q == LAST_IDX));
    assign accept     = sin_valid && sin_ready;
    assign word_valid = !fifo_empty;
    assign pop        = word_valid && word_ready;
    assign pos        = LSB_FIRST ? bit_idx_q : (LAST_IDX - bit_idx_q);
    assign sof_abort  = sof_abort_q;
    assign word_cnt   = word_cnt_q;

    // Bit placement, word completion and start-of-word restart.
    always_comb begin
        sreg_d      = sreg_q;
        bit_idx_d   = bit_idx_q;
        sof_abort_d = 1'b0;
        push        = 1'b0;
        push_word   = sreg_q;
        if (accept) begin
            if (sin_sof && (bit_idx_q != '0)) begin
                sreg_d            = '0;
                sreg_d[FIRST_POS] = sin_bit;
                bit_idx_d         = IDX_W'(1);
                sof_abort_d       = 1'b1;
            end else begin
                push_word[pos] = sin_bit;
                if (bit_idx_q == LAST_IDX) begin
                    push      = 1'b1;
                    sreg_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    sreg_d    = push_word;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
        end
    end

    // Delivered-word counter, wrapping naturally at 16 bits.
    always_comb begin
        word_cnt_d = word_cnt_q + {15'd0, pop};
    end

    // State registers; ready_en_q holds sin_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q      <= '0;
            bit_idx_q   <= '0;
            sof_abort_q <= 1'b0;
            word_cnt_q  <= 16'd0;
            ready_en_q  <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            bit_idx_q   <= bit_idx_d;
            sof_abort_q <= sof_abort_d;
            word_cnt_q  <= word_cnt_d;
            ready_en_q  <= 1'b1;
        end
    end

    y1_word_fifo2 #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (word_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_y1_word_deserializer.sv
// Bench for y1_word_deserializer: an LSB-first instance checked against a
// queue-based model of the serial protocol, plus an MSB-first instance fed
// the same stream whose words must be the bit-reverse of the model's words.
module tb_y1_word_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin_valid = 1'b0;
    logic        sin_bit = 1'b0;
    logic        sin_sof = 1'b0;
    logic        word_ready = 1'b0;

    logic        sin_ready, word_valid, sof_abort;
    logic [15:0] word_data, word_cnt;
    logic        m_sin_ready, m_word_valid, m_sof_abort;
    logic [15:0] m_word_data, m_word_cnt;

    always #5 clk = ~clk;

    y1_word_deserializer #(.WORD_W(16), .LSB_FIRST(1'b1), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin_valid  (sin_valid),
        .sin_bit    (sin_bit),
        .sin_sof    (sin_sof),
        .sin_ready  (sin_ready),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .sof_abort  (sof_abort),
        .word_cnt   (word_cnt)
    );

    y1_word_deserializer #(.WORD_W(16), .LSB_FIRST(1'b0), .DEPTH(2)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin_valid  (sin_valid),
        .sin_bit    (sin_bit),
        .sin_sof    (sin_sof),
        .sin_ready  (m_sin_ready),
        .word_valid (m_word_valid),
        .word_ready (word_ready),
        .word_data  (m_word_data),
        .sof_abort  (m_sof_abort),
        .word_cnt   (m_word_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits gathered so far, queue of buffered words, counters.
    int          md_n;
    logic [15:0] md_pw;
    logic [15:0] md_q [$];
    logic [15:0] md_cnt;
    logic        md_abort;
    int          abort_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    task automatic model_reset();
        md_n     = 0;
        md_pw    = '0;
        md_q.delete();
        md_cnt   = 16'd0;
        md_abort = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, compare, advance the model.
    task automatic step(input logic v, input logic b, input logic s, input logic r,
                        output logic acc);
        logic exp_rdy;
        logic pop;
        sin_valid  = v;
        sin_bit    = b;
        sin_sof    = s;
        word_ready = r;
        #1;
        exp_rdy = !(md_q.size() == 2 && md_n == 15);
        chk("sin_ready", sin_ready, exp_rdy);
        chk("msb_sin_ready", m_sin_ready, exp_rdy);
        chk("word_valid", word_valid, md_q.size() != 0);
        if (md_q.size() != 0) begin
            chk("word_data", word_data, md_q[0]);
            chk("msb_word_data", m_word_data, rev16(md_q[0]));
        end
        chk("sof_abort", sof_abort, md_abort);
        chk("word_cnt", word_cnt, md_cnt);
        if (sof_abort === 1'b1) abort_pulses++;
        pop      = (md_q.size() != 0) && r;
        acc      = v && exp_rdy;
        md_abort = 1'b0;
        if (pop) begin
            void'(md_q.pop_front());
            md_cnt++;
        end
        if (acc) begin
            if (s && md_n != 0) begin
                md_pw    = '0;
                md_pw[0] = b;
                md_n     = 1;
                md_abort = 1'b1;
            end else begin
                md_pw[md_n] = b;
                md_n++;
                if (md_n == 16) begin
                    md_q.push_back(md_pw);
                    md_pw = '0;
                    md_n  = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic s, input logic r);
        logic acc;
        int   k;
        k = 0;
        do begin
            step(1'b1, b, s, r, acc);
            k++;
        end while (!acc && k < 20);
        chk("send_bit_accepted", acc, 1'b1);
    endtask

    task automatic send_word(input logic [15:0] w, input logic r);
        for (int i = 0; i < 16; i++) send_bit(w[i], i == 0, r);
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, acc);
    endtask

    initial begin
        logic acc;
        logic [15:0] w;
        model_reset();
        abort_pulses = 0;

        // Reset state.
        #12;
        chk("rst_word_valid", word_valid, 1'b0);
        chk("rst_word_cnt", word_cnt, 16'd0);
        chk("rst_word_data", word_data, 16'd0);
        chk("rst_sof_abort", sof_abort, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word with immediate acceptance.
        send_word(16'h462C, 1'b1);
        chk("single_valid", word_valid, 1'b1);
        chk("single_data", word_data, 16'h462C);
        idle(1, 1'b1);
        chk("single_valid_drop", word_valid, 1'b0);
        chk("single_cnt", word_cnt, 16'd1);

        // Backpressure: two words fill the buffer, the third stalls on its last bit.
        send_word(16'h462C, 1'b0);
        send_word(16'h0001, 1'b0);
        for (int i = 0; i < 15; i++) send_bit(1'b1, i == 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, acc);
            chk("bp_stall_ready", sin_ready, 1'b0);
            chk("bp_head", word_data, 16'h462C);
        end
        send_bit(1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        chk("bp_cnt", word_cnt, 16'd4);
        chk("bp_drained", word_valid, 1'b0);

        // Start-of-word abort after five bits.
        abort_pulses = 0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1)), i == 0, 1'b0);
        send_word(16'hA5A5, 1'b0);
        idle(1, 1'b0);
        chk("abort_pulses", abort_pulses, 1);
        chk("abort_data", word_data, 16'hA5A5);
        idle(1, 1'b1);

        // Push and pop in the same cycle with one entry buffered.
        send_word(16'h1234, 1'b0);
        w = 16'h5678;
        for (int i = 0; i < 15; i++) send_bit(w[i], i == 0, 1'b0);
        send_bit(w[15], 1'b0, 1'b1);
        chk("pp_count", dut.u_fifo.count_q, 2'd1);
        chk("pp_head", word_data, 16'h5678);
        idle(1, 1'b1);

        // MSB-first instance: stream 16'h8001 top bit first.
        w = 16'h8001;
        for (int i = 0; i < 16; i++) send_bit(w[15-i], i == 0, 1'b0);
        chk("msb_data", m_word_data, 16'h8001);
        idle(1, 1'b1);

        // Counter wrap from a preloaded 16'hFFFF.
        force dut.word_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.word_cnt_q;
        @(negedge clk);
        chk("wrap_preload", word_cnt, 16'hFFFF);
        md_cnt = 16'hFFFF;
        send_word(16'h3C3C, 1'b1);
        idle(1, 1'b1);
        chk("wrap_cnt", word_cnt, 16'h0000);

        // Random traffic: gaps, occasional sof, random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 1'($urandom_range(1)), ($urandom % 16) == 0,
                 ($urandom % 3) != 0, acc);
        end
        idle(4, 1'b1);

        // Reset mid-stream with the buffer full.
        send_word(16'hBEEF, 1'b0);
        send_word(16'hCAFE, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1, i == 0, 1'b0);
        chk("pre_rst_full", dut.u_fifo.count_q, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_word_valid", word_valid, 1'b0);
        chk("mid_rst_word_cnt", word_cnt, 16'd0);
        chk("mid_rst_bit_idx", dut.bit_idx_q, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("post_rst_sin_ready", sin_ready, 1'b1);
        send_word(16'h0F0F, 1'b0);
        chk("post_rst_data", word_data, 16'h0F0F);
        idle(2, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Run-time bound so a stuck handshake cannot hang the simulation.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
